regfile_wb_scheduler: RTL and testbench

Shares the register file's single write port among three writeback requesters (ALU, load unit, multi-cycle unit) with round-robin arbitration and a valid/ready handshake, then drives the port's write-enable, address and data from a one-stage output register. It also keeps a 32-entry pending-write scoreboard, so issue logic can stall on registers whose results have not yet been written back. It sits between the execution units and the register file write port.

---
 rtl/regfile_wb_scheduler.sv | 113 +++++++++++
 tb/tb_regfile_wb_scheduler.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_scheduler.sv
// Round-robin arbiter sharing the register-file write port among three writeback units,
// with a registered write stage and a pending-write scoreboard for issue stalls.
module regfile_wb_scheduler #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [2:0]              req_valid,
  output logic [2:0]              req_ready,
  input  logic [3*ADDR_W-1:0]     req_addr,
  input  logic [3*DATA_W-1:0]     req_data,
  input  logic                    rsv_valid,
  input  logic [ADDR_W-1:0]       rsv_addr,
  output logic                    wb_we,
  output logic [ADDR_W-1:0]       wb_addr,
  output logic [DATA_W-1:0]       wb_data,
  output logic [(1<<ADDR_W)-1:0]  busy
);
  localparam int NREG = 1 << ADDR_W;
  localparam logic [NREG-1:0] ONE_HOT0 = NREG'(1);

  logic [1:0]        last_r;
  logic [1:0]        ord0_s, ord1_s, ord2_s;
  logic [1:0]        gidx_s;
  logic              gvalid_s;
  logic [ADDR_W-1:0] gaddr_s;
  logic [DATA_W-1:0] gdata_s;
  logic [NREG-1:0]   clr_s, set_s, busy_nxt_s;
  logic              wb_we_r;
  logic [ADDR_W-1:0] wb_addr_r;
  logic [DATA_W-1:0] wb_data_r;
  logic [NREG-1:0]   busy_r;

  // Priority order starts just after the last granted requester.
  always_comb begin
    ord0_s = 2'd0;
    ord1_s = 2'd1;
    ord2_s = 2'd2;
    case (last_r)
      2'd0: begin ord0_s = 2'd1; ord1_s = 2'd2; ord2_s = 2'd0; end
      2'd1: begin ord0_s = 2'd2; ord1_s = 2'd0; ord2_s = 2'd1; end
      default: begin ord0_s = 2'd0; ord1_s = 2'd1; ord2_s = 2'd2; end
    endcase
  end

  // Pick the highest-priority valid requester.
  always_comb begin
    gvalid_s = 1'b1;
    gidx_s   = ord0_s;
    if (req_valid[ord0_s]) begin
      gidx_s = ord0_s;
    end else if (req_valid[ord1_s]) begin
      gidx_s = ord1_s;
    end else if (req_valid[ord2_s]) begin
      gidx_s = ord2_s;
    end else begin
      gvalid_s = 1'b0;
      gidx_s   = 2'd0;
    end
  end

  // Route the granted requester's address and data.
  always_comb begin
    gaddr_s = req_addr[0 +: ADDR_W];
    gdata_s = req_data[0 +: DATA_W];
    case (gidx_s)
      2'd1: begin
        gaddr_s = req_addr[ADDR_W +: ADDR_W];
        gdata_s = req_data[DATA_W +: DATA_W];
      end
      2'd2: begin
        gaddr_s = req_addr[2*ADDR_W +: ADDR_W];
        gdata_s = req_data[2*DATA_W +: DATA_W];
      end
      default: begin
        gaddr_s = req_addr[0 +: ADDR_W];
        gdata_s = req_data[0 +: DATA_W];
      end
    endcase
  end

  assign req_ready = gvalid_s ? (3'b001 << gidx_s) : 3'b000;

  // Set is applied after clear so a same-edge reservation survives the accept.
  assign clr_s = gvalid_s ? (ONE_HOT0 << gaddr_s) : {NREG{1'b0}};
  assign set_s = (rsv_valid && (rsv_addr != {ADDR_W{1'b0}})) ? (ONE_HOT0 << rsv_addr) : {NREG{1'b0}};
  assign busy_nxt_s = ((busy_r & ~clr_s) | set_s) & ~ONE_HOT0;

  // Arbiter pointer, write stage and scoreboard state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r    <= 2'd2;
      wb_we_r   <= 1'b0;
      wb_addr_r <= {ADDR_W{1'b0}};
      wb_data_r <= {DATA_W{1'b0}};
      busy_r    <= {NREG{1'b0}};
    end else begin
      wb_we_r <= gvalid_s && (gaddr_s != {ADDR_W{1'b0}});
      busy_r  <= busy_nxt_s;
      if (gvalid_s) begin
        last_r    <= gidx_s;
        wb_addr_r <= gaddr_s;
        wb_data_r <= gdata_s;
      end
    end
  end

  assign wb_we   = wb_we_r;
  assign wb_addr = wb_addr_r;
  assign wb_data = wb_data_r;
  assign busy    = busy_r;
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: grants checked inline, register-file writes
// checked by a scoreboard monitor against an expected-write queue.
module tb_regfile_wb_scheduler;
  logic        clk;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic        rsv_valid;
  logic [4:0]  rsv_addr;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] busy;

  typedef struct {
    int          cyc;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [4:0]  a[3];
  logic [31:0] d[3];

  regfile_wb_scheduler #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Drive one cycle of stimulus, check the grant, queue any expected write.
  task automatic apply(input logic [2:0] v, input logic [2:0] exp_rdy,
                       input logic rv, input logic [4:0] ra);
    exp_t e;
    @(negedge clk);
    req_valid = v;
    rsv_valid = rv;
    rsv_addr  = ra;
    req_addr  = {a[2], a[1], a[0]};
    req_data  = {d[2], d[1], d[0]};
    #1;
    chk("req_ready", req_ready, exp_rdy);
    for (int i = 0; i < 3; i++) begin
      if (exp_rdy[i] && a[i] != 5'd0) begin
        e.cyc = cyc + 1; e.addr = a[i]; e.data = d[i];
        exp_q.push_back(e);
      end
    end
  endtask

  // Monitor: every write the DUT presents must match the queue head in cycle, addr, data.
  always @(negedge clk) begin
    exp_t h;
    if (rst_n) begin
      if (wb_we) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {27'd0, wb_addr}, 64'hFFFF);
        end else begin
          h = exp_q.pop_front();
          chk("wb_cycle", 64'(cyc), 64'(h.cyc));
          chk("wb_addr", {59'd0, wb_addr}, {59'd0, h.addr});
          chk("wb_data", {32'd0, wb_data}, {32'd0, h.data});
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        h = exp_q.pop_front();
        chk("missing_write", 64'd0, {59'd0, h.addr});
      end
    end
  end

  initial begin
    rst_n = 1'b0; req_valid = 3'b000; rsv_valid = 1'b0; rsv_addr = 5'd0;
    req_addr = 15'd0; req_data = 96'd0;
    for (int i = 0; i < 3; i++) begin a[i] = 5'd0; d[i] = 32'd0; end
    repeat (2) @(negedge clk);
    chk("rst_wb_we", wb_we, 1'b0);
    chk("rst_wb_addr", wb_addr, 5'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_busy", busy, 32'd0);
    rst_n = 1'b1;

    // single request
    a[0] = 5'd5; d[0] = 32'hDEADBEEF;
    apply(3'b001, 3'b001, 1'b0, 5'd0);
    apply(3'b000, 3'b000, 1'b0, 5'd0);
    apply(3'b000, 3'b000, 1'b0, 5'd0);

    // requesters 1,2 with last=0, then 0 joins
    a[1] = 5'd11; d[1] = 32'h1111_0001;
    a[2] = 5'd12; d[2] = 32'h2222_0002;
    apply(3'b110, 3'b010, 1'b0, 5'd0);
    a[0] = 5'd13; d[0] = 32'h0000_0013;
    apply(3'b101, 3'b100, 1'b0, 5'd0);
    apply(3'b001, 3'b001, 1'b0, 5'd0);

    // reservation of r7, accept three cycles later
    apply(3'b000, 3'b000, 1'b1, 5'd7);
    apply(3'b000, 3'b000, 1'b0, 5'd0);
    chk("busy7_c1", busy[7], 1'b1);
    apply(3'b000, 3'b000, 1'b0, 5'd0);
    chk("busy7_c2", busy[7], 1'b1);
    a[0] = 5'd7; d[0] = 32'h7777_7777;
    apply(3'b001, 3'b001, 1'b0, 5'd0);
    chk("busy7_c3", busy[7], 1'b1);
    apply(3'b000, 3'b000, 1'b0, 5'd0);
    chk("busy7_clr", busy[7], 1'b0);

    // same-edge reserve and accept of r9: set wins
    a[1] = 5'd9; d[1] = 32'h9999_0009;
    apply(3'b010, 3'b010, 1'b1, 5'd9);
    apply(3'b000, 3'b000, 1'b0, 5'd0);
    chk("busy9_set_wins", busy, 32'h0000_0200);

    // write to r0 and reservation of r0
    a[2] = 5'd0; d[2] = 32'h0000_1234;
    apply(3'b100, 3'b100, 1'b1, 5'd0);
    apply(3'b000, 3'b000, 1'b0, 5'd0);
    chk("r0_wb_we", wb_we, 1'b0);
    chk("r0_busy", busy, 32'h0000_0200);

    // asynchronous reset mid-operation
    a[0] = 5'd4; d[0] = 32'h4444_4444;
    apply(3'b001, 3'b001, 1'b1, 5'd3);
    apply(3'b000, 3'b000, 1'b0, 5'd0);
    chk("pre_rst_wb_we", wb_we, 1'b1);
    chk("pre_rst_busy", busy, 32'h0000_0208);
    #1 rst_n = 1'b0;
    #1;
    chk("async_wb_we", wb_we, 1'b0);
    chk("async_wb_addr", wb_addr, 5'd0);
    chk("async_wb_data", wb_data, 32'd0);
    chk("async_busy", busy, 32'd0);
    #3 rst_n = 1'b1;

    // three-way tie after reset: 0,1,2,0,1,2
    a[0] = 5'd1; a[1] = 5'd2; a[2] = 5'd3;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 3; i++) d[i] = 32'hC000_0000 | (k << 4) | i;
      apply(3'b111, 3'b001 << (k % 3), 1'b0, 5'd0);
    end
    repeat (3) apply(3'b000, 3'b000, 1'b0, 5'd0);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
